// File: rtl/dda_pkg.sv
// ---------------------------------------------------------------------------
// dda_pkg
// Shared types and constants for the DDA ray stepper:
//   status_e : result code reported with each finished ray
//   state_e  : control states of the stepper
//   FACE_*   : one-hot entry-axis encodings ([0]=X, [1]=Y, [2]=Z)
// ---------------------------------------------------------------------------
package dda_pkg;

  typedef enum logic [1:0] {
    HIT     = 2'd0,
    OOB     = 2'd1,
    TIMEOUT = 2'd2,
    ABORT   = 2'd3
  } status_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    WAIT  = 3'd2,
    STEP  = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam logic [2:0] FACE_NONE = 3'b000;
  localparam logic [2:0] FACE_X    = 3'b001;
  localparam logic [2:0] FACE_Y    = 3'b010;
  localparam logic [2:0] FACE_Z    = 3'b100;

endpackage

// File: rtl/dda_axis_select.sv
// ---------------------------------------------------------------------------
// dda_axis_select
// Combinational min-of-three over the per-axis tMax values. Ties resolve
// X over Y over Z. Output is a one-hot axis (FACE_X/FACE_Y/FACE_Z).
// Ports:
//   tmax_x_i/y_i/z_i : TIMER_WIDTH  current tMax per axis
//   sel_o            : 3            one-hot axis with the smallest tMax
// ---------------------------------------------------------------------------
module dda_axis_select
  import dda_pkg::*;
#(
  parameter int TIMER_WIDTH = 32
) (
  input  logic [TIMER_WIDTH-1:0] tmax_x_i,
  input  logic [TIMER_WIDTH-1:0] tmax_y_i,
  input  logic [TIMER_WIDTH-1:0] tmax_z_i,
  output logic [2:0]             sel_o
);

  always_comb begin
    sel_o = FACE_Z;
    if ((tmax_x_i <= tmax_y_i) && (tmax_x_i <= tmax_z_i)) begin
      sel_o = FACE_X;
    end else if (tmax_y_i <= tmax_z_i) begin
      sel_o = FACE_Y;
    end
  end

endmodule

// File: rtl/dda_ray_stepper.sv
// ---------------------------------------------------------------------------
// dda_ray_stepper
// DDA voxel-traversal engine. Accepts one ray job, walks it through a
// bounded voxel grid reading each voxel from an external RAM
// (req/gnt/rvalid), and reports HIT / OOB / TIMEOUT / ABORT with the
// terminating voxel, entry face, step count and entry distance.
// Ports:
//   clock, reset                 clock, synchronous active-high reset
//   job_*                        job handshake and ray setup fields
//   abort                        pulse: terminate the current job
//   ram_req/gnt/x/y/z            voxel read request (held until gnt)
//   ram_rvalid/ram_solid         voxel read response
//   res_*                        result, held until res_ready
//   busy                         engine is not idle
// Optional build macro DDA_STEP_TRACE_EN adds trace_valid/x/y/z/face, a
// one-cycle pulse after every step carrying the newly entered voxel.
// ---------------------------------------------------------------------------
module dda_ray_stepper
  import dda_pkg::*;
#(
  parameter int COORD_WIDTH      = 16,
  parameter int TIMER_WIDTH      = 32,
  parameter int STEP_COUNT_WIDTH = 16,
  parameter int GRID_X           = 256,
  parameter int GRID_Y           = 256,
  parameter int GRID_Z           = 256
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        job_valid,
  output logic                        job_ready,
  input  logic [COORD_WIDTH-1:0]      job_x,
  input  logic [COORD_WIDTH-1:0]      job_y,
  input  logic [COORD_WIDTH-1:0]      job_z,
  input  logic [2:0]                  job_dir_neg,
  input  logic [TIMER_WIDTH-1:0]      job_tmax_x,
  input  logic [TIMER_WIDTH-1:0]      job_tmax_y,
  input  logic [TIMER_WIDTH-1:0]      job_tmax_z,
  input  logic [TIMER_WIDTH-1:0]      job_tdelta_x,
  input  logic [TIMER_WIDTH-1:0]      job_tdelta_y,
  input  logic [TIMER_WIDTH-1:0]      job_tdelta_z,
  input  logic [STEP_COUNT_WIDTH-1:0] job_max_steps,
  input  logic                        abort,
  output logic                        ram_req,
  input  logic                        ram_gnt,
  output logic [COORD_WIDTH-1:0]      ram_x,
  output logic [COORD_WIDTH-1:0]      ram_y,
  output logic [COORD_WIDTH-1:0]      ram_z,
  input  logic                        ram_rvalid,
  input  logic                        ram_solid,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [1:0]                  res_status,
  output logic [COORD_WIDTH-1:0]      res_x,
  output logic [COORD_WIDTH-1:0]      res_y,
  output logic [COORD_WIDTH-1:0]      res_z,
  output logic [2:0]                  res_face,
  output logic [STEP_COUNT_WIDTH-1:0] res_steps,
  output logic [TIMER_WIDTH-1:0]      res_t,
  output logic                        busy
`ifdef DDA_STEP_TRACE_EN
  ,
  output logic                        trace_valid,
  output logic [COORD_WIDTH-1:0]      trace_x,
  output logic [COORD_WIDTH-1:0]      trace_y,
  output logic [COORD_WIDTH-1:0]      trace_z,
  output logic [2:0]                  trace_face
`endif
);

  localparam logic [COORD_WIDTH-1:0] GX = COORD_WIDTH'(GRID_X);
  localparam logic [COORD_WIDTH-1:0] GY = COORD_WIDTH'(GRID_Y);
  localparam logic [COORD_WIDTH-1:0] GZ = COORD_WIDTH'(GRID_Z);

  // Saturating unsigned add: tMax pins at all-ones instead of wrapping so a
  // saturated axis never looks "nearer" than the others.
  function automatic logic [TIMER_WIDTH-1:0] sat_add(
    input logic [TIMER_WIDTH-1:0] a,
    input logic [TIMER_WIDTH-1:0] b
  );
    logic [TIMER_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[TIMER_WIDTH] ? {TIMER_WIDTH{1'b1}} : s[TIMER_WIDTH-1:0];
  endfunction

  state_e                        state_q, state_d;
  status_e                       status_q, status_d;
  logic [2:0][COORD_WIDTH-1:0]   pos_q, pos_d;       // index 0=X, 1=Y, 2=Z
  logic [2:0][TIMER_WIDTH-1:0]   tmax_q, tmax_d;
  logic [2:0][TIMER_WIDTH-1:0]   tdelta_q, tdelta_d;
  logic [2:0]                    dir_q, dir_d;
  logic [STEP_COUNT_WIDTH-1:0]   max_q, max_d;
  logic [STEP_COUNT_WIDTH-1:0]   steps_q, steps_d;
  logic [2:0]                    face_q, face_d;
  logic [TIMER_WIDTH-1:0]        t_q, t_d;
  logic                          abort_q, abort_d;

  logic [2:0] sel;
  logic       oob;
  logic       abort_now;

  dda_axis_select #(
    .TIMER_WIDTH(TIMER_WIDTH)
  ) u_axis_select (
    .tmax_x_i(tmax_q[0]),
    .tmax_y_i(tmax_q[1]),
    .tmax_z_i(tmax_q[2]),
    .sel_o   (sel)
  );

  assign oob = (pos_q[0] >= GX) || (pos_q[1] >= GY) || (pos_q[2] >= GZ);

  // An abort arriving in the same cycle as the decision point counts as
  // already pending.
  assign abort_now = abort_q | abort;

  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    pos_d    = pos_q;
    tmax_d   = tmax_q;
    tdelta_d = tdelta_q;
    dir_d    = dir_q;
    max_d    = max_q;
    steps_d  = steps_q;
    face_d   = face_q;
    t_d      = t_q;
    abort_d  = abort_q;
    ram_req  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (job_valid) begin
          pos_d    = {job_z, job_y, job_x};
          tmax_d   = {job_tmax_z, job_tmax_y, job_tmax_x};
          tdelta_d = {job_tdelta_z, job_tdelta_y, job_tdelta_x};
          dir_d    = job_dir_neg;
          max_d    = job_max_steps;
          steps_d  = '0;
          face_d   = FACE_NONE;
          t_d      = '0;
          abort_d  = 1'b0;
          state_d  = FETCH;
        end
      end

      FETCH: begin
        abort_d = abort_now;
        if (oob) begin
          // Out-of-grid voxel is never read; it terminates immediately.
          status_d = OOB;
          state_d  = DONE;
        end else begin
          ram_req = 1'b1;
          if (ram_gnt) begin
            state_d = WAIT;
          end
        end
      end

      WAIT: begin
        abort_d = abort_now;
        if (ram_rvalid) begin
          state_d = DONE;
          if (abort_now) begin
            status_d = ABORT;
          end else if (ram_solid) begin
            status_d = HIT;
          end else if (steps_q == max_q) begin
            status_d = TIMEOUT;
          end else begin
            state_d = STEP;
          end
        end
      end

      STEP: begin
        if (abort_now) begin
          status_d = ABORT;
          state_d  = DONE;
        end else begin
          for (int i = 0; i < 3; i++) begin
            if (sel[i]) begin
              t_d       = tmax_q[i];
              tmax_d[i] = sat_add(tmax_q[i], tdelta_q[i]);
              pos_d[i]  = dir_q[i] ? (pos_q[i] - COORD_WIDTH'(1))
                                   : (pos_q[i] + COORD_WIDTH'(1));
            end
          end
          face_d  = sel;
          steps_d = steps_q + STEP_COUNT_WIDTH'(1);
          state_d = FETCH;
        end
      end

      DONE: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      status_q <= HIT;
      pos_q    <= '0;
      tmax_q   <= '0;
      tdelta_q <= '0;
      dir_q    <= '0;
      max_q    <= '0;
      steps_q  <= '0;
      face_q   <= FACE_NONE;
      t_q      <= '0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      pos_q    <= pos_d;
      tmax_q   <= tmax_d;
      tdelta_q <= tdelta_d;
      dir_q    <= dir_d;
      max_q    <= max_d;
      steps_q  <= steps_d;
      face_q   <= face_d;
      t_q      <= t_d;
      abort_q  <= abort_d;
    end
  end

  assign job_ready  = (state_q == IDLE);
  assign res_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign ram_x      = pos_q[0];
  assign ram_y      = pos_q[1];
  assign ram_z      = pos_q[2];
  assign res_status = status_q;
  assign res_x      = pos_q[0];
  assign res_y      = pos_q[1];
  assign res_z      = pos_q[2];
  assign res_face   = face_q;
  assign res_steps  = steps_q;
  assign res_t      = t_q;

`ifdef DDA_STEP_TRACE_EN
  logic trace_valid_q;

  // pos_q/face_q already hold the new voxel in the cycle after STEP.
  always_ff @(posedge clock) begin
    if (reset) begin
      trace_valid_q <= 1'b0;
    end else begin
      trace_valid_q <= (state_q == STEP) && !abort_now;
    end
  end

  assign trace_valid = trace_valid_q;
  assign trace_x     = pos_q[0];
  assign trace_y     = pos_q[1];
  assign trace_z     = pos_q[2];
  assign trace_face  = face_q;
`endif

endmodule

// File: tb/tb_dda_ray_stepper.sv
module tb_dda_ray_stepper;

  localparam int GX = 40;
  localparam int GY = 36;
  localparam int GZ = 48;
  localparam int S_HIT = 0, S_OOB = 1, S_TIMEOUT = 2, S_ABORT = 3;

  logic        clock, reset;
  logic        job_valid, job_ready;
  logic [15:0] job_x, job_y, job_z;
  logic [2:0]  job_dir_neg;
  logic [31:0] job_tmax_x, job_tmax_y, job_tmax_z;
  logic [31:0] job_tdelta_x, job_tdelta_y, job_tdelta_z;
  logic [15:0] job_max_steps;
  logic        abort;
  logic        ram_req, ram_gnt, ram_rvalid, ram_solid;
  logic [15:0] ram_x, ram_y, ram_z;
  logic        res_valid, res_ready;
  logic [1:0]  res_status;
  logic [15:0] res_x, res_y, res_z;
  logic [2:0]  res_face;
  logic [15:0] res_steps;
  logic [31:0] res_t;
  logic        busy;

  dda_ray_stepper #(
    .COORD_WIDTH(16), .TIMER_WIDTH(32), .STEP_COUNT_WIDTH(16),
    .GRID_X(GX), .GRID_Y(GY), .GRID_Z(GZ)
  ) dut (
    .clock(clock), .reset(reset),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_x(job_x), .job_y(job_y), .job_z(job_z), .job_dir_neg(job_dir_neg),
    .job_tmax_x(job_tmax_x), .job_tmax_y(job_tmax_y), .job_tmax_z(job_tmax_z),
    .job_tdelta_x(job_tdelta_x), .job_tdelta_y(job_tdelta_y), .job_tdelta_z(job_tdelta_z),
    .job_max_steps(job_max_steps), .abort(abort),
    .ram_req(ram_req), .ram_gnt(ram_gnt),
    .ram_x(ram_x), .ram_y(ram_y), .ram_z(ram_z),
    .ram_rvalid(ram_rvalid), .ram_solid(ram_solid),
    .res_valid(res_valid), .res_ready(res_ready), .res_status(res_status),
    .res_x(res_x), .res_y(res_y), .res_z(res_z),
    .res_face(res_face), .res_steps(res_steps), .res_t(res_t), .busy(busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- voxel world ----------------
  int          map_mode = 0;   // 0 empty, 1 single solid voxel, 2 hashed
  int unsigned sol_x, sol_y, sol_z, seed;

  function automatic bit solid_at(input int unsigned x, input int unsigned y, input int unsigned z);
    case (map_mode)
      1: return (x == sol_x) && (y == sol_y) && (z == sol_z);
      2: return ((x * 7 + y * 13 + z * 5 + seed) % 11) == 0;
      default: return 1'b0;
    endcase
  endfunction

  // ---------------- RAM responder ----------------
  int          gnt_delay = 0, rv_lat = 1;
  int          gcnt = 0, lcnt = 0, n_gnt = 0, req_hold = 0, last_hold = 0;
  bit          pend = 0, req_wait = 0, req_drop = 0, oob_req = 0;
  int unsigned ax, ay, az;

  initial begin
    ram_gnt = 1'b0; ram_rvalid = 1'b0; ram_solid = 1'b0;
    forever begin
      @(negedge clock);
      ram_gnt = 1'b0; ram_rvalid = 1'b0; ram_solid = 1'b0;
      if (ram_req && (ram_x >= GX || ram_y >= GY || ram_z >= GZ)) oob_req = 1;
      if (req_wait && !ram_req && !reset) req_drop = 1;
      if (!ram_req) req_wait = 0;
      if (pend) begin
        if (lcnt <= 1) begin
          ram_rvalid = 1'b1;
          ram_solid  = solid_at(ax, ay, az);
          pend = 0;
        end else lcnt--;
      end else if (ram_req) begin
        req_hold++;
        if (gcnt >= gnt_delay) begin
          ram_gnt = 1'b1;
          ax = ram_x; ay = ram_y; az = ram_z;
          pend = 1; lcnt = rv_lat; gcnt = 0; n_gnt++;
          last_hold = req_hold; req_hold = 0; req_wait = 0;
        end else begin
          gcnt++;
          req_wait = 1;
        end
      end
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    int          st;
    logic [15:0] x, y, z;
    logic [2:0]  f;
    logic [15:0] steps;
    logic [31:0] t;
  } exp_s;

  function automatic exp_s model(input int unsigned sx, sy, sz, input logic [2:0] dn,
                                 input longint unsigned tmx, tmy, tmz,
                                 input longint unsigned tdx, tdy, tdz, input int maxs);
    exp_s e;
    longint unsigned c[3], tm[3], td[3];
    int lim[3];
    int a, steps;
    c = '{sx, sy, sz}; tm = '{tmx, tmy, tmz}; td = '{tdx, tdy, tdz};
    lim = '{GX, GY, GZ};
    steps = 0; e.f = 3'b000; e.t = 32'd0; e.st = S_TIMEOUT;
    for (int it = 0; it <= maxs + 1; it++) begin
      if (c[0] >= lim[0] || c[1] >= lim[1] || c[2] >= lim[2]) begin e.st = S_OOB; break; end
      if (solid_at(c[0], c[1], c[2])) begin e.st = S_HIT; break; end
      if (steps == maxs) begin e.st = S_TIMEOUT; break; end
      a = 0;
      if (tm[1] < tm[a]) a = 1;
      if (tm[2] < tm[a]) a = 2;
      e.t   = tm[a][31:0];
      tm[a] = tm[a] + td[a];
      if (tm[a] > 64'hFFFF_FFFF) tm[a] = 64'hFFFF_FFFF;
      c[a]  = dn[a] ? (c[a] + 65535) % 65536 : (c[a] + 1) % 65536;
      e.f   = 3'(1 << a);
      steps++;
    end
    e.x = c[0][15:0]; e.y = c[1][15:0]; e.z = c[2][15:0];
    e.steps = 16'(steps);
    return e;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic start_job(input int unsigned sx, sy, sz, input logic [2:0] dn,
                           input logic [31:0] tmx, tmy, tmz, tdx, tdy, tdz, input int maxs);
    int n;
    n = 0;
    while (!job_ready && n < 50) begin tick(); n++; end
    chk("job_ready_wait", {95'd0, job_ready}, 96'd1);
    job_x = 16'(sx); job_y = 16'(sy); job_z = 16'(sz); job_dir_neg = dn;
    job_tmax_x = tmx; job_tmax_y = tmy; job_tmax_z = tmz;
    job_tdelta_x = tdx; job_tdelta_y = tdy; job_tdelta_z = tdz;
    job_max_steps = 16'(maxs);
    job_valid = 1'b1;
    tick();
    job_valid = 1'b0;
  endtask

  task automatic finish_job(input string tag, input exp_s e, input int bp);
    int n;
    n = 0;
    while (!res_valid && n < 3000) begin tick(); n++; end
    chk({tag, "_res_valid"}, {95'd0, res_valid}, 96'd1);
    chk({tag, "_status"}, {94'd0, res_status}, 96'(e.st));
    chk({tag, "_xyz"}, {48'd0, res_x, res_y, res_z}, {48'd0, e.x, e.y, e.z});
    chk({tag, "_face"}, {93'd0, res_face}, {93'd0, e.f});
    chk({tag, "_steps"}, {80'd0, res_steps}, {80'd0, e.steps});
    chk({tag, "_t"}, {64'd0, res_t}, {64'd0, e.t});
    for (int i = 0; i < bp; i++) begin
      tick();
      chk({tag, "_hold"},
          {25'd0, res_valid, job_ready, res_status, res_face, res_x, res_y, res_z, res_steps},
          {25'd0, 1'b1, 1'b0, 2'(e.st), e.f, e.x, e.y, e.z, e.steps});
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk({tag, "_idle_after"}, {94'd0, job_ready, busy}, 96'b10);
  endtask

  task automatic run(input string tag, input int unsigned sx, sy, sz, input logic [2:0] dn,
                     input logic [31:0] tmx, tmy, tmz, tdx, tdy, tdz, input int maxs, input int bp);
    exp_s e;
    e = model(sx, sy, sz, dn, tmx, tmy, tmz, tdx, tdy, tdz, maxs);
    start_job(sx, sy, sz, dn, tmx, tmy, tmz, tdx, tdy, tdz, maxs);
    finish_job(tag, e, bp);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    exp_s e;
    int   n, n0;
    job_valid = 0; job_x = 0; job_y = 0; job_z = 0; job_dir_neg = 0;
    job_tmax_x = 0; job_tmax_y = 0; job_tmax_z = 0;
    job_tdelta_x = 0; job_tdelta_y = 0; job_tdelta_z = 0;
    job_max_steps = 0; abort = 0; res_ready = 0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    // reset state
    chk("reset_ctrl", {92'd0, job_ready, busy, ram_req, res_valid}, 96'b1000);
    chk("reset_res", {res_status, res_face, res_x, res_y, res_z, res_steps}, 96'd0);
    chk("reset_t", {64'd0, res_t}, 96'd0);

    // 1: hit along +X
    map_mode = 1; sol_x = 5; sol_y = 2; sol_z = 2;
    run("t1_hit", 2, 2, 2, 3'b000, 1, 5, 5, 1, 10, 10, 100, 0);

    // solid start voxel: no step taken
    sol_x = 9; sol_y = 9; sol_z = 9;
    run("solid_start", 9, 9, 9, 3'b111, 3, 2, 1, 1, 1, 1, 10, 0);

    // 2: wrap below zero on X -> OOB, wrapped voxel never requested
    map_mode = 0; oob_req = 0;
    run("t2_oob", 0, 0, 0, 3'b001, 1, 9, 9, 1, 1, 1, 100, 0);
    chk("t2_no_oob_req", {95'd0, oob_req}, 96'd0);

    // 3: step budget
    run("t3_to4", 10, 10, 10, 3'b000, 3, 4, 5, 5, 5, 5, 4, 0);
    run("t3_to0", 10, 10, 10, 3'b000, 3, 4, 5, 5, 5, 5, 0, 0);

    // 4: slow RAM with abort during WAIT
    gnt_delay = 3; rv_lat = 5; req_drop = 0;
    e = '{st: S_ABORT, x: 7, y: 8, z: 9, f: 3'b000, steps: 0, t: 0};
    n0 = n_gnt;
    start_job(7, 8, 9, 3'b000, 1, 2, 3, 1, 1, 1, 20);
    n = 0;
    while (n_gnt == n0 && n < 20) begin tick(); n++; end
    chk("t4_gnt_seen", {95'd0, n_gnt != n0}, 96'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    finish_job("t4_abort", e, 0);
    chk("t4_req_hold", 96'(last_hold), 96'd4);
    chk("t4_req_no_drop", {95'd0, req_drop}, 96'd0);
    gnt_delay = 0; rv_lat = 1;

    // 5: equal tMax -> X, then Y, then Z; back-pressure on last
    run("t5_m1", 20, 20, 20, 3'b000, 4, 4, 4, 8, 8, 8, 1, 0);
    run("t5_m2", 20, 20, 20, 3'b000, 4, 4, 4, 8, 8, 8, 2, 0);
    run("t5_m3", 20, 20, 20, 3'b000, 4, 4, 4, 8, 8, 8, 3, 10);

    // 6: reset during WAIT, late rvalid must be ignored
    rv_lat = 6;
    n0 = n_gnt;
    start_job(3, 3, 3, 3'b000, 1, 2, 3, 1, 1, 1, 20);
    n = 0;
    while (n_gnt == n0 && n < 20) begin tick(); n++; end
    chk("t6_gnt_seen", {95'd0, n_gnt != n0}, 96'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_after_reset", {92'd0, job_ready, busy, ram_req, res_valid}, 96'b1000);
    repeat (8) tick();
    chk("t6_late_rvalid", {94'd0, busy, res_valid}, 96'd0);
    rv_lat = 1;
    map_mode = 1; sol_x = 5; sol_y = 2; sol_z = 2;
    run("t6_new", 2, 2, 2, 3'b000, 1, 5, 5, 1, 10, 10, 100, 0);

    // randomized rays in a hashed world
    map_mode = 2;
    for (int k = 0; k < 40; k++) begin
      logic [31:0] tx, ty, tz, dx, dy, dz;
      seed = $urandom;
      gnt_delay = $urandom_range(0, 2);
      rv_lat = $urandom_range(1, 3);
      tx = $urandom_range(0, 20); ty = $urandom_range(0, 20); tz = $urandom_range(0, 20);
      dx = $urandom_range(1, 15); dy = $urandom_range(1, 15); dz = $urandom_range(1, 15);
      if ($urandom_range(0, 5) == 0) begin tx = 32'hFFFF_FFF0; dx = 32'h100; end
      run("rnd", $urandom_range(0, GX + 3), $urandom_range(0, GY + 3), $urandom_range(0, GZ + 3),
          3'($urandom), tx, ty, tz, dx, dy, dz, $urandom_range(0, 25), $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
